// File: rtl/instr_fetch_if.sv
// Program-load write port of the instruction fetch unit.
// The loader drives address/data/valid; the fetch unit answers with ready.
interface instr_fetch_if;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_addr;
    logic [7:0] load_data;

    modport master (output load_valid, output load_addr, output load_data, input load_ready);
    modport slave  (input load_valid, input load_addr, input load_data, output load_ready);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch / sequencing unit: 16-word program store, PC, branch
// decode (JMP/BEQ/BNE/HALT) and a saturating executed-instruction counter.
module instr_fetch #(
    parameter logic [3:0] START_PC = 4'd0,
    parameter int         CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_fetch_if.slave     load_bus,
    input  logic             run,
    input  logic             alu_eq,
    output logic [7:0]       instr,
    output logic             instr_valid,
    output logic [3:0]       pc,
    output logic             set_pc,
    output logic             halted,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_nxt_s;
    logic [3:0]       pc_r, pc_nxt_s;
    logic [CNT_W-1:0] icount_r, icount_nxt_s;
    logic             first_r, first_nxt_s;
    logic [7:0]       mem_r [16];
    logic [7:0]       instr_s;
    logic             wr_en_s;

    // Control words have opcode 2'b11; sub-op 01 = BEQ, 10 = BNE, 00 = JMP.
    function automatic logic branch_taken(input logic [7:0] word, input logic eq);
        logic taken;
        if (word[7:6] == 2'b11) begin
            case (word[5:4])
                2'b00:   taken = 1'b1;
                2'b01:   taken = eq;
                2'b10:   taken = ~eq;
                default: taken = 1'b0;
            endcase
        end else begin
            taken = 1'b0;
        end
        return taken;
    endfunction

    function automatic logic is_halt(input logic [7:0] word);
        return (word[7:4] == 4'b1111);
    endfunction

    assign instr_s  = mem_r[pc_r];
    assign wr_en_s  = load_bus.load_valid && (state_r != ST_RUN);

    // Program store; cleared on reset, writable only outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (wr_en_s) begin
            mem_r[load_addr_idx()] <= load_bus.load_data;
        end
    end

    function automatic logic [3:0] load_addr_idx();
        return load_bus.load_addr;
    endfunction

    // Sequencer state, PC, counter and first-cycle flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= START_PC;
            icount_r <= {CNT_W{1'b0}};
            first_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            icount_r <= icount_nxt_s;
            first_r  <= first_nxt_s;
        end
    end

    // Next-state: start on run outside RUN; in RUN advance, branch or halt.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        icount_nxt_s = icount_r;
        first_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (run) begin
                    state_nxt_s  = ST_RUN;
                    pc_nxt_s     = START_PC;
                    icount_nxt_s = {CNT_W{1'b0}};
                    first_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s  = state_r;
                end
            end
            ST_RUN: begin
                if (icount_r != CNT_MAX) begin
                    icount_nxt_s = icount_r + CNT_ONE;
                end else begin
                    icount_nxt_s = icount_r;
                end
                if (is_halt(instr_s)) begin
                    state_nxt_s = ST_HALT;
                end else if (branch_taken(instr_s, alu_eq)) begin
                    pc_nxt_s = instr_s[3:0];
                end else begin
                    pc_nxt_s = pc_r + 4'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign load_bus.load_ready = (state_r != ST_RUN);
    assign instr       = instr_s;
    assign instr_valid = (state_r == ST_RUN);
    assign pc          = pc_r;
    assign set_pc      = first_r;
    assign halted      = (state_r == ST_HALT);
    assign icount      = icount_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program model predicts each RUN cycle.
module tb_instr_fetch;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       alu_eq;
    logic [7:0] instr;
    logic       instr_valid;
    logic [3:0] pc;
    logic       set_pc;
    logic       halted;
    logic [7:0] icount;

    instr_fetch_if lbus ();

    instr_fetch #(.START_PC(4'd0), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_bus   (lbus),
        .run        (run),
        .alu_eq     (alu_eq),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .set_pc     (set_pc),
        .halted     (halted),
        .icount     (icount)
    );

    typedef struct {
        logic [3:0] pc;
        logic [7:0] instr;
        logic       sp;
        int         ic;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] tb_mem [16];
    int         n_checks = 0;
    int         n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check_eq({tag, "_setpc"}, 32'(set_pc), 32'd0);
        check_eq({tag, "_halted"}, 32'(halted), 32'd0);
        check_eq({tag, "_ready"}, 32'(lbus.load_ready), 32'd1);
        check_eq({tag, "_pc"}, 32'(pc), 32'd0);
        check_eq({tag, "_icount"}, 32'(icount), 32'd0);
        check_eq({tag, "_instr"}, 32'(instr), 32'd0);
    endtask

    task automatic load_word(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        check_eq("load_ready", 32'(lbus.load_ready), 32'd1);
        lbus.load_valid = 1'b1;
        lbus.load_addr  = a;
        lbus.load_data  = d;
        tb_mem[a]       = d;
        @(negedge clk);
        lbus.load_valid = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Model the program, push expectations, start the run and compare each RUN cycle.
    task automatic run_prog(input logic eq, input int ncyc, input logic poke,
                            input logic ld, input logic [3:0] la, input logic [7:0] ldd);
        exp_t       e;
        logic [3:0] p;
        logic [7:0] w;
        logic       hit;
        int         k;
        int         ic_end;
        if (ld) tb_mem[la] = ldd;
        p   = 4'd0;
        hit = 1'b0;
        k   = 0;
        while (!hit && k < ncyc) begin
            w       = tb_mem[p];
            e.pc    = p;
            e.instr = w;
            e.sp    = (k == 0);
            e.ic    = (k > 255) ? 255 : k;
            sb.push_back(e);
            if (w[7:6] == 2'b11) begin
                case (w[5:4])
                    2'b00:   p = w[3:0];
                    2'b01:   p = eq ? w[3:0] : p + 4'd1;
                    2'b10:   p = eq ? p + 4'd1 : w[3:0];
                    default: hit = 1'b1;
                endcase
            end else begin
                p = p + 4'd1;
            end
            k++;
        end
        ic_end = (k > 255) ? 255 : k;

        @(negedge clk);
        run    = 1'b1;
        alu_eq = eq;
        if (ld) begin
            lbus.load_valid = 1'b1;
            lbus.load_addr  = la;
            lbus.load_data  = ldd;
        end
        @(negedge clk);
        run             = 1'b0;
        lbus.load_valid = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("run_valid", 32'(instr_valid), 32'd1);
            check_eq("run_pc", 32'(pc), 32'(e.pc));
            check_eq("run_instr", 32'(instr), 32'(e.instr));
            check_eq("run_setpc", 32'(set_pc), 32'(e.sp));
            check_eq("run_icount", 32'(icount), 32'(e.ic));
            if (poke) begin
                check_eq("lock_ready", 32'(lbus.load_ready), 32'd0);
                lbus.load_valid = 1'b1;
                lbus.load_addr  = 4'd0;
                lbus.load_data  = 8'hAA;
                run             = 1'b1;
            end
            @(negedge clk);
        end
        lbus.load_valid = 1'b0;
        run             = 1'b0;
        if (hit) begin
            check_eq("halt_halted", 32'(halted), 32'd1);
            check_eq("halt_valid", 32'(instr_valid), 32'd0);
            check_eq("halt_pc", 32'(pc), 32'(p));
            check_eq("halt_icount", 32'(icount), 32'(ic_end));
            check_eq("halt_ready", 32'(lbus.load_ready), 32'd1);
        end else begin
            check_eq("still_running", 32'(instr_valid), 32'd1);
            check_eq("next_pc", 32'(pc), 32'(p));
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        run             = 1'b0;
        alu_eq          = 1'b0;
        lbus.load_valid = 1'b0;
        lbus.load_addr  = 4'd0;
        lbus.load_data  = 8'h00;
        for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Straight-line word then HALT, HALT loaded on the same edge as run start.
        load_word(4'd0, 8'h12);
        run_prog(1'b0, 32, 1'b0, 1'b1, 4'd1, 8'hF0);

        // BEQ taken and not taken, second run restarts from HALT.
        load_word(4'd0, 8'hD5);
        load_word(4'd5, 8'hF0);
        run_prog(1'b1, 32, 1'b0, 1'b0, 4'd0, 8'h00);
        run_prog(1'b0, 32, 1'b0, 1'b0, 4'd0, 8'h00);

        // BNE / JMP loop long enough to saturate the counter, then abort.
        load_word(4'd0, 8'hE3);
        load_word(4'd3, 8'hC0);
        run_prog(1'b0, 300, 1'b0, 1'b0, 4'd0, 8'h00);
        check_eq("sat_icount", 32'(icount), 32'd255);
        async_reset("rst_loop");

        // Lockout: writes attempted throughout RUN must not land.
        load_word(4'd0, 8'h01);
        load_word(4'd1, 8'h01);
        load_word(4'd2, 8'hF0);
        run_prog(1'b0, 32, 1'b1, 1'b0, 4'd0, 8'h00);
        run_prog(1'b0, 32, 1'b0, 1'b0, 4'd0, 8'h00);
        async_reset("rst_lock");

        // PC wrap 15 -> 0 with all-0x01 program.
        for (int i = 0; i < 16; i++) load_word(4'(i), 8'h01);
        run_prog(1'b0, 20, 1'b0, 1'b0, 4'd0, 8'h00);
        async_reset("rst_wrap");

        // Reset mid-run at pc 7, then rerun over cleared memory.
        for (int i = 0; i < 16; i++) load_word(4'(i), 8'h01);
        run_prog(1'b0, 7, 1'b0, 1'b0, 4'd0, 8'h00);
        check_eq("abort_pc7", 32'(pc), 32'd7);
        async_reset("rst_mid");
        run_prog(1'b1, 5, 1'b0, 1'b0, 4'd0, 8'h00);
        async_reset("rst_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
